// File: rtl/fetch_inst_responder.sv
// Fetch-side responder: forwards word fetch requests to instruction memory and returns
// instruction words in request order, with credit-based backpressure and flush discard.
module fetch_inst_responder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DEPTH_N = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iFETCH_REQ,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oFETCH_LOCK,
    output logic        oINST_VALID,
    output logic [31:0] oINST,
    input  logic        iINST_LOCK,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_LOCK,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    output logic        oERR_UNEXPECTED
);

    logic [DEPTH_N:0]   inflight_q, inflight_d;
    logic [DEPTH_N:0]   discard_q, discard_d;
    logic [DEPTH_N:0]   count_q, count_d;
    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic               err_q, err_d;
    logic [31:0]        fifo_q [DEPTH];

    logic [DEPTH_N+1:0] credit_used;
    logic               fetch_lock;
    logic               accept;
    logic               ret_ok;
    logic               unexpected;
    logic               push;
    logic               pop;

    // Requests at memory plus words already buffered must never exceed the FIFO depth.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign fetch_lock  = iRESET_SYNC || iFLUSH || iMEM_LOCK ||
                         (credit_used >= (DEPTH_N + 2)'(DEPTH));
    assign accept      = iFETCH_REQ && !fetch_lock;
    assign ret_ok      = iMEM_VALID && (inflight_q != '0);
    assign unexpected  = iMEM_VALID && (inflight_q == '0);
    assign push        = ret_ok && (discard_q == '0) && !iFLUSH;
    assign pop         = (count_q != '0) && !iINST_LOCK && !iFLUSH;

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !ret_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && ret_ok) begin
            inflight_d = inflight_q - 1'b1;
        end

        // Everything still at memory after a flush cycle belongs to the dead stream.
        discard_d = discard_q;
        if (iFLUSH) begin
            discard_d = inflight_q - {{DEPTH_N{1'b0}}, ret_ok};
        end else if (ret_ok && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{DEPTH_N{1'b0}}, push} - {{DEPTH_N{1'b0}}, pop};
        end

        err_d = err_q || unexpected;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (iRESET_SYNC) begin
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= iMEM_DATA;
            end
        end
    end

    assign oFETCH_LOCK     = fetch_lock;
    assign oMEM_REQ        = accept;
    assign oMEM_ADDR       = {iFETCH_ADDR[31:2], 2'b00};
    assign oINST_VALID     = (count_q != '0);
    assign oINST           = fifo_q[rd_ptr_q];
    assign oERR_UNEXPECTED = err_q;

endmodule

// File: doc/fetch_inst_responder.md
Name: fetch_inst_responder

Overview:
- Responder side of the fetch request/instruction-return interface.
- Accepts word fetch requests from the fetch stage, forwards them to the instruction memory port, and returns instruction words to fetch strictly in request order.
- Backpressures fetch through a lock, buffers memory returns while fetch is locked, and silently discards in-flight returns after a pipeline flush (event start or branch-predict redirect).

Parameters:
DEPTH, 16, max outstanding requests (in flight at memory plus buffered); power of two, at least 2
DEPTH_N, 4, log2(DEPTH)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous reset, same effect as inRESET
iFLUSH  in  1  discard all pending/buffered instructions
iFETCH_REQ  in  1  fetch request strobe
iFETCH_ADDR  in  32  fetch byte address
oFETCH_LOCK  out  1  request not accepted this cycle
oINST_VALID  out  1  instruction word available
oINST  out  32  instruction word
iINST_LOCK  in  1  fetch stage stalled, hold output
oMEM_REQ  out  1  memory read request
oMEM_ADDR  out  32  memory word address
iMEM_LOCK  in  1  memory cannot accept request
iMEM_VALID  in  1  memory read data valid (in order)
iMEM_DATA  in  32  memory read data
oERR_UNEXPECTED  out  1  sticky: iMEM_VALID with nothing in flight

Behaviour:
- Reset value of all outputs and state is 0: inflight, discard, FIFO pointers/count, error flag. iRESET_SYNC has the same effect synchronously.
- Counters: inflight (DEPTH_N+1 bits) counts requests issued to memory and not yet returned. buffered is the response FIFO count. discard (DEPTH_N+1 bits) is at most inflight.
- oFETCH_LOCK is combinational: iRESET_SYNC || iFLUSH || iMEM_LOCK || (inflight + buffered >= DEPTH).
- Accept occurs when iFETCH_REQ && !oFETCH_LOCK.
  - oMEM_REQ equals accept, in the same cycle (no added latency).
  - oMEM_ADDR = {iFETCH_ADDR[31:2], 2'b00}.
  - Accept increments inflight.
- Return:
  - iMEM_VALID decrements inflight.
  - If discard != 0, the word is dropped and discard decrements.
  - Otherwise the word is written to the response FIFO.
  - The credit rule guarantees the FIFO never overflows.
- Response FIFO is show-ahead, depth DEPTH.
  - oINST_VALID = !empty. oINST = head.
  - Pop when oINST_VALID && !iINST_LOCK.
  - Push and pop in the same cycle are allowed, including when full (count unchanged).
  - Empty-to-valid latency is 1 cycle after iMEM_VALID; no bypass.
  - oINST is stable while iINST_LOCK is high.
- Flush:
  - iFLUSH clears the FIFO in that cycle; any same-cycle push and pop are ignored.
  - discard <= inflight minus (1 if iMEM_VALID this cycle, else 0). That is, every request still in flight after this cycle is marked for discard.
  - No accept occurs in a flush cycle (lock is high).
  - Back-to-back flushes recompute discard the same way.
  - Valid words returned before the flush are lost.
- Priority: reset > iRESET_SYNC > iFLUSH > normal operation.
- Requests are allowed during discard; their returns are kept, because discard only covers older in-flight words (memory returns in order).
- Error: iMEM_VALID while inflight == 0 sets oERR_UNEXPECTED (sticky until reset). inflight must not underflow; it holds 0. The data is dropped.
- No internal FSM beyond the counters. Aggregate states are EMPTY, RUN, FULL-CREDIT and DRAIN (discard != 0), all derived from the counters.
- Counter width arithmetic: inflight + buffered is computed at DEPTH_N+2 bits; no wrap.

Test Plan:
- Single fetch: req addr 0x103 with memory returning 0xDEADBEEF 3 cycles later -> oMEM_ADDR=0x100 same cycle; oINST_VALID=1 with oINST=0xDEADBEEF one cycle after iMEM_VALID; popped next cycle with iINST_LOCK=0.
- Streaming 20 requests (0x0, 0x4, …) with iINST_LOCK=1 throughout and memory 1-cycle latency -> exactly 16 accepted, then oFETCH_LOCK=1. Release the lock -> words emerge in order 0..15, then requests resume.
- Flush with 3 in flight and 2 buffered -> oINST_VALID drops the next cycle. The next 3 iMEM_VALID beats are dropped. A new request at 0x200 issued during discard returns as the first oINST_VALID word.
- Flush in the same cycle as iMEM_VALID with inflight=2 -> discard=1. Exactly one further return is dropped.
- iMEM_LOCK=1 with iFETCH_REQ=1 -> oFETCH_LOCK=1, oMEM_REQ=0, inflight unchanged. Simultaneous push/pop with FIFO full -> count stays 16, order preserved.
- iMEM_VALID with inflight=0 -> oERR_UNEXPECTED=1 and stays 1; oINST_VALID stays 0. Assert iRESET_SYNC mid-stream -> all counters and outputs return to 0 the next cycle.
